// File: rtl/game_pkg.sv
// Shared game-flow encodings and default world/level geometry for the
// sequencer and the screen overlay.
package game_pkg;

  typedef enum logic [2:0] {
    ST_START     = 3'd0,
    ST_PLAYING   = 3'd1,
    ST_LEVEL_INC = 3'd2,
    ST_WORLD_INC = 3'd3,
    ST_LIFE_LOST = 3'd4,
    ST_LOSE      = 3'd5,
    ST_WIN       = 3'd6
  } game_status_t;

  localparam int NUM_WORLDS_DEF       = 4;
  localparam int LEVELS_PER_WORLD_DEF = 4;

endpackage

// File: rtl/game_sequencer_rise_detect.sv
// Rising-edge detector: registered previous value AND-NOT current.
// Previous value resets to 0, so an input high out of reset counts as an edge.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) r_prev <= 1'b0;
    else     r_prev <= i_sig;
  end

  assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: sequences worlds, levels and lives, holds banner
// states for HOLD_CYCLES and pulses restart on every entry into play.
module game_sequencer
  import game_pkg::*;
#(
  parameter int NUM_WORLDS       = NUM_WORLDS_DEF,
  parameter int LEVELS_PER_WORLD = LEVELS_PER_WORLD_DEF,
  parameter int START_LIVES      = 3,
  parameter int MAX_LIVES        = 9,
  parameter int HOLD_CYCLES      = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       level_complete,
  input  logic       player_died,
  output logic [2:0] game_status,
  output logic [2:0] world,
  output logic [2:0] level,
  output logic [3:0] lives,
  output logic       restart
);

  localparam int                HOLD_W     = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [2:0]        LAST_WORLD = 3'(NUM_WORLDS - 1);
  localparam logic [2:0]        LAST_LEVEL = 3'(LEVELS_PER_WORLD - 1);
  localparam logic [3:0]        LIVES_INIT = 4'(START_LIVES);
  localparam logic [3:0]        LIVES_MAX  = 4'(MAX_LIVES);

  function automatic logic [3:0] lives_inc(input logic [3:0] v);
    return (v >= LIVES_MAX) ? LIVES_MAX : v + 4'd1;
  endfunction

  function automatic logic [3:0] lives_dec(input logic [3:0] v);
    return (v == 4'd0) ? 4'd0 : v - 4'd1;
  endfunction

  game_status_t      r_state, w_state_nxt;
  logic [2:0]        r_world, w_world_nxt;
  logic [2:0]        r_level, w_level_nxt;
  logic [3:0]        r_lives, w_lives_nxt;
  logic [HOLD_W-1:0] r_hold,  w_hold_nxt;
  logic              r_restart, w_restart_nxt;
  logic              w_start_rise, w_lc_rise, w_died_rise;

  rise_detect u_start_rise (.clk(clk), .rst(rst), .i_sig(start_btn),      .o_rise(w_start_rise));
  rise_detect u_lc_rise    (.clk(clk), .rst(rst), .i_sig(level_complete), .o_rise(w_lc_rise));
  rise_detect u_died_rise  (.clk(clk), .rst(rst), .i_sig(player_died),    .o_rise(w_died_rise));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_START;
      r_world   <= 3'd0;
      r_level   <= 3'd0;
      r_lives   <= LIVES_INIT;
      r_hold    <= '0;
      r_restart <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_world   <= w_world_nxt;
      r_level   <= w_level_nxt;
      r_lives   <= w_lives_nxt;
      r_hold    <= w_hold_nxt;
      r_restart <= w_restart_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_world_nxt = r_world;
    w_level_nxt = r_level;
    w_lives_nxt = r_lives;
    w_hold_nxt  = '0;
    case (r_state)
      ST_START: begin
        if (w_start_rise) begin
          w_state_nxt = ST_PLAYING;
          w_world_nxt = 3'd0;
          w_level_nxt = 3'd0;
          w_lives_nxt = LIVES_INIT;
        end
      end
      ST_PLAYING: begin
        // level_complete takes priority over a simultaneous death
        if (w_lc_rise) begin
          if (r_level == LAST_LEVEL) begin
            if (r_world == LAST_WORLD) begin
              w_state_nxt = ST_WIN;
            end else begin
              w_state_nxt = ST_WORLD_INC;
              w_world_nxt = r_world + 3'd1;
              w_level_nxt = 3'd0;
              w_lives_nxt = lives_inc(r_lives);
            end
          end else begin
            w_state_nxt = ST_LEVEL_INC;
            w_level_nxt = r_level + 3'd1;
          end
        end else if (w_died_rise) begin
          if (r_lives <= 4'd1) begin
            w_state_nxt = ST_LOSE;
            w_lives_nxt = 4'd0;
          end else begin
            w_state_nxt = ST_LIFE_LOST;
            w_lives_nxt = lives_dec(r_lives);
          end
        end
      end
      ST_LEVEL_INC, ST_WORLD_INC, ST_LIFE_LOST: begin
        if (r_hold == HOLD_LAST) w_state_nxt = ST_PLAYING;
        else                     w_hold_nxt  = r_hold + HOLD_W'(1);
      end
      ST_LOSE, ST_WIN: begin
        if (w_start_rise) w_state_nxt = ST_START;
      end
      default: w_state_nxt = ST_START;
    endcase
  end

  always_comb begin
    w_restart_nxt = (w_state_nxt == ST_PLAYING) && (r_state != ST_PLAYING);
    game_status   = r_state;
    world         = r_world;
    level         = r_level;
    lives         = r_lives;
    restart       = r_restart;
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with short holds and a 2x2 world map;
// a second instance with START_LIVES=MAX_LIVES=9 covers lives saturation.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_btn, level_complete, player_died;
  logic [2:0] game_status, world, level;
  logic [3:0] lives;
  logic       restart;
  logic [2:0] game_status9, world9, level9;
  logic [3:0] lives9;
  logic       restart9;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  game_sequencer #(
    .NUM_WORLDS(2), .LEVELS_PER_WORLD(2), .START_LIVES(3), .MAX_LIVES(9), .HOLD_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .level_complete(level_complete),
    .player_died(player_died), .game_status(game_status), .world(world),
    .level(level), .lives(lives), .restart(restart)
  );

  game_sequencer #(
    .NUM_WORLDS(2), .LEVELS_PER_WORLD(2), .START_LIVES(9), .MAX_LIVES(9), .HOLD_CYCLES(4)
  ) dut9 (
    .clk(clk), .rst(rst), .start_btn(start_btn), .level_complete(level_complete),
    .player_died(player_died), .game_status(game_status9), .world(world9),
    .level(level9), .lives(lives9), .restart(restart9)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_btn = 1'b1;
    tick();
  endtask

  // Remaining 3 hold cycles, then the return to PLAYING with restart.
  task automatic finish_hold(input string tag, input logic [2:0] hold_st);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({tag, "_hold_st"}, game_status, hold_st);
      chk({tag, "_hold_rs"}, restart, 0);
    end
    tick();
    chk({tag, "_back_st"}, game_status, 1);
    chk({tag, "_back_rs"}, restart, 1);
    tick();
    chk({tag, "_after_rs"}, restart, 0);
  endtask

  initial begin
    rst = 1'b1; start_btn = 1'b0; level_complete = 1'b0; player_died = 1'b0;
    tick(); tick();
    chk("rst_st", game_status, 0);
    chk("rst_world", world, 0);
    chk("rst_level", level, 0);
    chk("rst_lives", lives, 3);
    chk("rst_rs", restart, 0);
    rst = 1'b0;
    tick();
    chk("idle_st", game_status, 0);

    pulse_start();
    chk("start_st", game_status, 1);
    chk("start_rs", restart, 1);
    chk("start_lives", lives, 3);
    chk("start_lives9", lives9, 9);
    start_btn = 1'b0;
    tick();
    chk("play_rs", restart, 0);
    chk("play_st", game_status, 1);

    // level_complete held high across the hold and beyond
    level_complete = 1'b1;
    tick();
    chk("linc_st", game_status, 2);
    chk("linc_level", level, 1);
    finish_hold("linc", 3'd2);
    chk("held_lc_level", level, 1);
    chk("held_lc_st", game_status, 1);
    level_complete = 1'b0;
    tick();

    level_complete = 1'b1;
    tick();
    chk("winc_st", game_status, 3);
    chk("winc_world", world, 1);
    chk("winc_level", level, 0);
    chk("winc_lives", lives, 4);
    chk("winc_lives9_sat", lives9, 9);
    level_complete = 1'b0;
    finish_hold("winc", 3'd3);

    level_complete = 1'b1;
    tick();
    chk("w1_linc_level", level, 1);
    level_complete = 1'b0;
    finish_hold("w1_linc", 3'd2);

    level_complete = 1'b1;
    tick();
    chk("win_st", game_status, 6);
    chk("win_rs", restart, 0);
    level_complete = 1'b0;
    tick();
    chk("win_hold_st", game_status, 6);

    pulse_start();
    chk("win2start_st", game_status, 0);
    chk("win2start_world", world, 1);
    chk("win2start_lives", lives, 4);
    start_btn = 1'b0;
    tick();
    pulse_start();
    chk("restart_st", game_status, 1);
    chk("restart_world", world, 0);
    chk("restart_level", level, 0);
    chk("restart_lives", lives, 3);
    chk("restart_rs", restart, 1);
    start_btn = 1'b0;
    tick();

    // ignored start_btn while playing
    pulse_start();
    chk("play_start_ign", game_status, 1);
    start_btn = 1'b0;
    tick();

    player_died = 1'b1;
    tick();
    chk("die1_st", game_status, 4);
    chk("die1_lives", lives, 2);
    player_died = 1'b0;
    finish_hold("die1", 3'd4);
    player_died = 1'b1;
    tick();
    chk("die2_st", game_status, 4);
    chk("die2_lives", lives, 1);
    player_died = 1'b0;
    finish_hold("die2", 3'd4);
    player_died = 1'b1;
    tick();
    chk("die3_st", game_status, 5);
    chk("die3_lives", lives, 0);
    player_died = 1'b0;
    tick();
    level_complete = 1'b1;
    tick();
    chk("lose_lc_st", game_status, 5);
    chk("lose_lc_level", level, 0);
    level_complete = 1'b0;
    tick();

    pulse_start();
    chk("lose2start_st", game_status, 0);
    start_btn = 1'b0;
    tick();
    pulse_start();
    chk("replay_lives", lives, 3);
    start_btn = 1'b0;
    tick();

    level_complete = 1'b1;
    player_died = 1'b1;
    tick();
    chk("both_st", game_status, 2);
    chk("both_lives", lives, 3);
    chk("both_level", level, 1);
    level_complete = 1'b0;
    player_died = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("midhold_rst_st", game_status, 0);
    chk("midhold_rst_lives", lives, 3);
    chk("midhold_rst_level", level, 0);

    // input already high as reset releases counts as an edge
    start_btn = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_edge_st", game_status, 1);
    chk("rst_edge_rs", restart, 1);
    start_btn = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
